// File: rtl/display_scan_reader.sv
// Seven-segment scan reader: samples a multiplexed display bus, debounces each
// digit and publishes a 4-digit frame once every digit has been captured.

module display_scan_slot (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [3:0] val,
    input  logic       bad,
    output logic [3:0] q,
    output logic       inv
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= 4'h0;
            inv <= 1'b0;
        end else if (wr) begin
            q   <= val;
            inv <= bad;
        end
    end
endmodule

module display_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digits_out,
    output logic        frame_valid,
    output logic        frame_err
);
    localparam int         NUM_DIGITS = 4;
    localparam logic [7:0] STABLE     = 8'(STABLE_CYCLES);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t                          state, state_nxt;
    logic [6:0]                      seg_s, seg_p;
    logic [NUM_DIGITS-1:0]           an_s, an_p;
    logic [7:0]                      cnt, cnt_nxt;
    logic [NUM_DIGITS-1:0]           capture_mask;
    logic [NUM_DIGITS-1:0][3:0]      shadow;
    logic [NUM_DIGITS-1:0]           inv;
    logic                            qual, same, cap, bad;
    logic [3:0]                      dval;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = {1'b0, 4'd0};
            7'h30:   decode = {1'b0, 4'd1};
            7'h6D:   decode = {1'b0, 4'd2};
            7'h79:   decode = {1'b0, 4'd3};
            7'h33:   decode = {1'b0, 4'd4};
            7'h5B:   decode = {1'b0, 4'd5};
            7'h5F:   decode = {1'b0, 4'd6};
            7'h70:   decode = {1'b0, 4'd7};
            7'h7F:   decode = {1'b0, 4'd8};
            7'h73:   decode = {1'b0, 4'd9};
            default: decode = {1'b1, 4'hF};
        endcase
    endfunction

    // Sample stage plus a one-cycle-old copy used for the stability compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s <= '0;
            an_s  <= '0;
            seg_p <= '0;
            an_p  <= '0;
        end else begin
            seg_s <= seg_in;
            an_s  <= an_in;
            seg_p <= seg_s;
            an_p  <= an_s;
        end
    end

    assign qual        = (an_s != '0) && ((an_s & (an_s - 4'd1)) == '0);
    assign same        = (seg_s == seg_p) && (an_s == an_p);
    assign {bad, dval} = decode(seg_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETTLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Any change while holding is scored exactly like a SETTLE sample, so a
    // one-cycle threshold can capture right on the change.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        if (!(state == HOLD && same)) begin
            state_nxt = SETTLE;
            if (!qual)
                cnt_nxt = '0;
            else if (same)
                cnt_nxt = (cnt >= STABLE) ? STABLE : cnt + 8'd1;
            else
                cnt_nxt = 8'd1;
            if (qual && cnt_nxt == STABLE) begin
                cap       = 1'b1;
                state_nxt = HOLD;
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slot
        display_scan_slot u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .wr   (cap & an_s[k]),
            .val  (dval),
            .bad  (bad),
            .q    (shadow[k]),
            .inv  (inv[k])
        );
    end

    // A capture landing on the publish cycle seeds the next frame's mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            capture_mask <= '0;
            digits_out   <= '0;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (&capture_mask) begin
                digits_out   <= shadow;
                frame_err    <= |inv;
                frame_valid  <= 1'b1;
                capture_mask <= cap ? an_s : '0;
            end else if (cap) begin
                capture_mask <= capture_mask | an_s;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_reader.sv
// Directed bench for display_scan_reader: a default-threshold instance and a
// single-cycle-threshold instance sharing clock and reset.

module tb_display_scan_reader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in, seg1;
    logic [3:0]  an_in, an1;
    logic [15:0] digits_out, digits1;
    logic        frame_valid, frame_err, fv1, fe1;
    int          checks = 0;
    int          errors = 0;
    int          fv_cnt = 0;
    int          base;

    always #5 clk = ~clk;

    display_scan_reader #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in),
        .digits_out(digits_out), .frame_valid(frame_valid), .frame_err(frame_err)
    );

    display_scan_reader #(.STABLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg_in(seg1), .an_in(an1),
        .digits_out(digits1), .frame_valid(fv1), .frame_err(fe1)
    );

    always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_in = s;
        an_in  = a;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [6:0] p0, p1, p2, p3);
        drive(p0, 4'b0001, 6);
        drive(p1, 4'b0010, 6);
        drive(p2, 4'b0100, 6);
        drive(p3, 4'b1000, 6);
        drive(7'h00, 4'b0000, 3);
    endtask

    initial begin
        rst_n = 1'b0;
        seg_in = '0; an_in = '0; seg1 = '0; an1 = '0;
        repeat (2) @(negedge clk);
        check("rst_digits", digits_out, 0);
        check("rst_fv", frame_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_mask", dut.capture_mask, 0);
        check("rst_digits1", digits1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame
        scan4(7'h79, 7'h5B, 7'h30, 7'h7E);
        check("basic_fv_cnt", fv_cnt, 1);
        check("basic_digits", digits_out, 16'h0153);
        check("basic_err", frame_err, 0);
        check("basic_mask", dut.capture_mask, 0);

        // Short hold on digit 2 does not capture
        base = fv_cnt;
        drive(7'h7E, 4'b0001, 6);
        drive(7'h30, 4'b0010, 6);
        drive(7'h6D, 4'b0100, 3);
        check("short_mask", dut.capture_mask, 4'b0011);
        drive(7'h73, 4'b1000, 0);
        scan4(7'h33, 7'h5F, 7'h70, 7'h73);
        check("short_fv_cnt", fv_cnt - base, 1);
        check("short_digits", digits_out, 16'h9764);

        // Bad pattern on digit 1, then a clean frame
        base = fv_cnt;
        scan4(7'h7E, 7'h00, 7'h6D, 7'h79);
        check("bad_fv_cnt", fv_cnt - base, 1);
        check("bad_digits", digits_out, 16'h32F0);
        check("bad_err", frame_err, 1);
        scan4(7'h7E, 7'h7F, 7'h6D, 7'h79);
        check("clean_fv_cnt", fv_cnt - base, 2);
        check("clean_digits", digits_out, 16'h3280);
        check("clean_err", frame_err, 0);

        // Multi-hot select is ignored
        base = fv_cnt;
        drive(7'h7E, 4'b0001, 6);
        drive(7'h30, 4'b0010, 6);
        drive(7'h6D, 4'b0100, 6);
        drive(7'h7E, 4'b0011, 10);
        check("multi_mask", dut.capture_mask, 4'b0111);
        check("multi_no_fv", fv_cnt - base, 0);
        drive(7'h79, 4'b1000, 6);
        drive(7'h00, 4'b0000, 3);
        check("multi_fv_cnt", fv_cnt - base, 1);
        check("multi_digits", digits_out, 16'h3210);

        // Reset mid-frame discards partial captures
        drive(7'h7E, 4'b0001, 6);
        drive(7'h30, 4'b0010, 6);
        drive(7'h6D, 4'b0100, 6);
        check("mid_mask", dut.capture_mask, 4'b0111);
        #2 rst_n = 1'b0;
        #1;
        check("async_digits", digits_out, 0);
        check("async_mask", dut.capture_mask, 0);
        check("async_fv", frame_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        base = fv_cnt;
        scan4(7'h73, 7'h7F, 7'h70, 7'h5F);
        check("rst_fv_cnt", fv_cnt - base, 1);
        check("rst_new_digits", digits_out, 16'h6789);
        check("rst_new_err", frame_err, 0);

        // Single-cycle threshold: one select per cycle
        seg1 = 7'h5F; an1 = 4'b0001; @(negedge clk);
        seg1 = 7'h70; an1 = 4'b0010; @(negedge clk);
        seg1 = 7'h7F; an1 = 4'b0100; @(negedge clk);
        seg1 = 7'h73; an1 = 4'b1000; @(negedge clk);
        seg1 = 7'h00; an1 = 4'b0000; @(negedge clk);
        check("s1_fv_early", fv1, 0);
        @(negedge clk);
        check("s1_fv", fv1, 1);
        check("s1_digits", digits1, 16'h9876);
        check("s1_err", fe1, 0);
        @(negedge clk);
        check("s1_fv_after", fv1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
